dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (core + debug/loader) arbiter in front of a single-ported data memory.
// Combinational grants, one-cycle read return, fairness run limit and core stall counter.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [3:0]        c_be,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              d_lock,
    output logic              m_en,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic [15:0]       c_wait_cnt
);

    typedef enum logic [1:0] {IDLE, CORE_RD, DBG_RD} state_t;

    localparam logic [3:0] MAX_RUN_L = 4'(MAX_RUN);

    state_t      state_reg, state_next;
    logic [3:0]  run_cnt_reg, run_cnt_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;

    // Core normally wins a contest; debug is forced through once the core
    // has taken MAX_RUN contested grants in a row, and always wins under lock.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            c_gnt = c_req && !d_lock && !(d_req && (run_cnt_reg == MAX_RUN_L));
            d_gnt = d_req && !c_gnt;
        end
    end

    always_comb begin
        m_en    = c_gnt | d_gnt;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_be    = c_be;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    always_comb begin
        run_cnt_next = run_cnt_reg;
        if (d_gnt || !d_req) begin
            run_cnt_next = '0;
        end else if (c_gnt && (run_cnt_reg != MAX_RUN_L)) begin
            run_cnt_next = run_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (c_req && !c_gnt && (wait_cnt_reg != 16'hFFFF)) begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
        end
    end

    // Response FSM: a read granted this cycle returns data next cycle.
    always_comb begin
        state_next = IDLE;
        c_rvalid   = 1'b0;
        c_rdata    = '0;
        d_rvalid   = 1'b0;
        d_rdata    = '0;
        if (c_gnt && !c_we) begin
            state_next = CORE_RD;
        end else if (d_gnt && !d_we) begin
            state_next = DBG_RD;
        end
        if (!rst) begin
            case (state_reg)
                CORE_RD: begin
                    c_rvalid = 1'b1;
                    c_rdata  = m_rdata;
                end
                DBG_RD: begin
                    d_rvalid = 1'b1;
                    d_rdata  = m_rdata;
                end
                default: ;
            endcase
        end
    end

    assign c_wait_cnt = rst ? 16'h0000 : wait_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            run_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            run_cnt_reg  <= run_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random traffic against a rule-level reference model,
// followed by directed scenarios for latency, fairness, lock, reset and saturation.
module tb_dmem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int MAX_RUN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              c_req, c_we, d_req, d_we, d_lock;
    logic [3:0]        c_be, d_be;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [31:0]       c_wdata, d_wdata, m_rdata;
    logic              c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0]       c_rdata, d_rdata, m_wdata;
    logic              m_en, m_we;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [15:0]       c_wait_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state: contested core grants since debug last got through,
    // stall count, and which port (if any) has a read in flight.
    int mdl_run  = 0;
    int mdl_wait = 0;
    int mdl_pend = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_lock(d_lock),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .c_wait_cnt(c_wait_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare every output with the model, then advance the model.
    task automatic cyc();
        bit exp_c, exp_d, contested_loss;
        #1;
        contested_loss = d_req && (mdl_run >= MAX_RUN);
        exp_c = !rst && c_req && !d_lock && !contested_loss;
        exp_d = !rst && d_req && !exp_c;
        chk("c_gnt", 64'(c_gnt), 64'(exp_c));
        chk("d_gnt", 64'(d_gnt), 64'(exp_d));
        chk("m_en", 64'(m_en), 64'(exp_c || exp_d));
        chk("m_we", 64'(m_we), exp_c ? 64'(c_we) : exp_d ? 64'(d_we) : 64'd0);
        chk("m_be", 64'(m_be), exp_c ? 64'(c_be) : exp_d ? 64'(d_be) : 64'd0);
        chk("m_addr", 64'(m_addr), exp_c ? 64'(c_addr) : exp_d ? 64'(d_addr) : 64'd0);
        chk("m_wdata", 64'(m_wdata), exp_c ? 64'(c_wdata) : exp_d ? 64'(d_wdata) : 64'd0);
        chk("c_rvalid", 64'(c_rvalid), 64'(!rst && mdl_pend == 1));
        chk("d_rvalid", 64'(d_rvalid), 64'(!rst && mdl_pend == 2));
        chk("c_rdata", 64'(c_rdata), (!rst && mdl_pend == 1) ? 64'(m_rdata) : 64'd0);
        chk("d_rdata", 64'(d_rdata), (!rst && mdl_pend == 2) ? 64'(m_rdata) : 64'd0);
        chk("c_wait_cnt", 64'(c_wait_cnt), rst ? 64'd0 : 64'(mdl_wait));
        @(posedge clk);
        if (rst) begin
            mdl_run  = 0;
            mdl_wait = 0;
            mdl_pend = 0;
        end else begin
            if (exp_d || !d_req) mdl_run = 0;
            else if (exp_c)      mdl_run = (mdl_run < MAX_RUN) ? mdl_run + 1 : MAX_RUN;
            if (c_req && !exp_c && mdl_wait < 65535) mdl_wait++;
            mdl_pend = (exp_c && !c_we) ? 1 : (exp_d && !d_we) ? 2 : 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        d_lock = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        cyc();
        cyc();
        rst = 0;
    endtask

    initial begin
        string pat;
        int    w0;
        rst = 1;
        idle_inputs();
        c_req = 1; d_req = 1;
        cyc();
        c_req = 0; d_req = 0;
        cyc();
        rst = 0;
        $display("reset: outputs idle, c_wait_cnt=%0d", c_wait_cnt);

        // Random traffic, including occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            c_req   = $urandom_range(0, 2) != 0;
            d_req   = $urandom_range(0, 2) == 0;
            c_we    = $urandom_range(0, 1);
            d_we    = $urandom_range(0, 1);
            c_be    = 4'($urandom);
            d_be    = 4'($urandom);
            c_addr  = $urandom;
            d_addr  = $urandom;
            c_wdata = $urandom;
            d_wdata = $urandom;
            d_lock  = ($urandom_range(0, 7) == 0);
            m_rdata = $urandom;
            cyc();
        end
        $display("random: 3000 cycles, checks so far %0d", checks);

        // Core read at 0x10 with one-cycle data return
        do_reset();
        c_req = 1; c_we = 0; c_be = 4'hF; c_addr = 32'h10;
        #1;
        chk("rd_gnt", 64'(c_gnt), 64'd1);
        chk("rd_addr", 64'(m_addr), 64'h10);
        cyc();
        c_req = 0; m_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_rvalid", 64'(c_rvalid), 64'd1);
        chk("rd_rdata", 64'(c_rdata), 64'hDEADBEEF);
        chk("rd_d_rvalid", 64'(d_rvalid), 64'd0);
        cyc();
        $display("core read 0x10 -> 0x%h", 32'hDEADBEEF);

        // Both ports requesting continuously: debug forced in every MAX_RUN+1 grants
        do_reset();
        c_req = 1; c_we = 1; d_req = 1; d_we = 1;
        w0 = 0;
        pat = "";
        for (int i = 0; i < 10; i++) begin
            #1;
            pat = {pat, c_gnt ? "C" : (d_gnt ? "D" : "-")};
            chk("fair_gnt", 64'(d_gnt), 64'((i % (MAX_RUN + 1)) == MAX_RUN));
            cyc();
        end
        #1;
        chk("fair_wait", 64'(c_wait_cnt), 64'(w0 + 10 / (MAX_RUN + 1)));
        $display("fairness pattern %s", pat);

        // Debug lock starves the core
        do_reset();
        d_lock = 1; c_req = 1; c_we = 0;
        for (int i = 0; i < 10; i++) cyc();
        #1;
        chk("lock_wait", 64'(c_wait_cnt), 64'd10);
        $display("lock: c_wait_cnt=%0d after 10 cycles", c_wait_cnt);

        // Back-to-back core read then debug read
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h40;
        cyc();
        c_req = 0; d_req = 1; d_we = 0; d_addr = 32'h80; m_rdata = 32'h11111111;
        #1;
        chk("b2b_c_rvalid", 64'(c_rvalid), 64'd1);
        chk("b2b_c_rdata", 64'(c_rdata), 64'h11111111);
        chk("b2b_d_gnt", 64'(d_gnt), 64'd1);
        cyc();
        d_req = 0; m_rdata = 32'h22222222;
        #1;
        chk("b2b_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("b2b_d_rdata", 64'(d_rdata), 64'h22222222);
        chk("b2b_c_idle", 64'(c_rvalid), 64'd0);
        cyc();
        $display("back-to-back reads returned core and debug data");

        // Reset right after a granted read drops the response
        do_reset();
        d_lock = 1; c_req = 1; c_we = 0; c_addr = 32'h4;
        cyc();
        d_lock = 0;
        cyc();
        rst = 1; c_req = 0; m_rdata = 32'hCAFEF00D;
        #1;
        chk("rst_rvalid", 64'(c_rvalid), 64'd0);
        chk("rst_wait", 64'(c_wait_cnt), 64'd0);
        cyc();
        rst = 0;
        #1;
        chk("rel_rvalid", 64'(c_rvalid), 64'd0);
        c_req = 1; c_addr = 32'h8;
        #1;
        chk("rel_gnt", 64'(c_gnt), 64'd1);
        cyc();
        c_req = 0;
        cyc();
        $display("reset after read: response dropped, next read granted");

        // Stall counter saturation
        do_reset();
        d_lock = 1; c_req = 1;
        for (int i = 0; i < 70000; i++) cyc();
        #1;
        chk("sat_wait", 64'(c_wait_cnt), 64'hFFFF);
        $display("saturation: c_wait_cnt=0x%h", c_wait_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
